// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage of the 5-stage MIPS pipeline.
//
// Registers the EX->MEM bus. A load's SRAM read data arrives in the first
// cycle the entry sits here. The data is aligned to the load address and
// sign- or zero-extended for lw/lb/lbu/lh/lhu. The stage then drives the
// MEM->WB bus and the combinational forward path back to decode.
//
// Optional build macro: MS_ADDR_CHK_EN
//   When defined, misaligned lw/lh/lhu loads raise ms_adel. Such a load has
//   its register write and its forward valid suppressed. When undefined,
//   ms_adel is tied low. The port list is the same in both builds.
//
// Ports
//   clk             in   core clock, rising edge
//   resetn          in   asynchronous active-low reset
//   ws_allowin      in   WB can accept this cycle
//   ms_allowin      out  MEM can accept from EX
//   es_to_ms_valid  in   EX bus valid
//   es_to_ms_bus    in   {lhu,lh,lbu,lb,lw,dest_valid,res_from_mem,gr_we,
//                        dest[4:0],result[31:0],pc[31:0]}
//   data_sram_rdata in   SRAM read data, valid the cycle after EX's request
//   ms_to_ws_valid  out  MEM bus valid
//   ms_to_ws_bus    out  {gr_we,dest[4:0],final_result[31:0],pc[31:0]}
//   ms_to_ds_fw     out  {valid,dest[4:0],final_result[31:0]}
//   ms_adel         out  load address-misalignment flag
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 77,
  parameter int MS_TO_WS_BUS_WD = 70,
  parameter int MS_FW_WD        = 38
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_FW_WD-1:0]        ms_to_ds_fw,
  output logic                       ms_adel
);

  // Select, align and extend load data from the 32-bit read word.
  function automatic logic [31:0] load_align(input logic [31:0] w,
                                             input logic [1:0]  a,
                                             input logic lw, input logic lb,
                                             input logic lbu, input logic lh,
                                             input logic lhu);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [31:0] ext;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h  = a[1] ? w[31:16] : w[15:0];
    bs = b;
    hs = h;
    if (lw)       ext = w;
    else if (lb)  ext = bs;
    else if (lbu) ext = {24'b0, b};
    else if (lh)  ext = hs;
    else if (lhu) ext = {16'b0, h};
    else          ext = w;
    return $unsigned(ext);
  endfunction

  logic                       vld_p1;
  logic                       fresh_p1;
  logic                       hold_vld_p1;
  logic [ES_TO_MS_BUS_WD-1:0] bus_p1;
  logic [31:0]                rdata_hold_p1;

  logic        ld_lhu, ld_lh, ld_lbu, ld_lb, ld_lw;
  logic        dest_valid, res_from_mem, gr_we;
  logic [4:0]  dest;
  logic [31:0] result, pc;
  logic [31:0] mem_data, final_result;
  logic        ms_ready_go, accept, leave, capture, gr_we_out, fw_valid;

  assign {ld_lhu, ld_lh, ld_lbu, ld_lb, ld_lw, dest_valid, res_from_mem,
          gr_we, dest, result, pc} = bus_p1;

  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !vld_p1 || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = vld_p1 && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign leave          = ms_to_ws_valid && ws_allowin;
  // SRAM output follows EX's next address, so a stalled load must keep its
  // first-cycle data locally.
  assign capture        = fresh_p1 && res_from_mem && !ws_allowin;

  // ---- stage p1: MEM registers ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1      <= 1'b0;
      fresh_p1    <= 1'b0;
      hold_vld_p1 <= 1'b0;
    end else begin
      if (ms_allowin) vld_p1 <= es_to_ms_valid;
      fresh_p1 <= accept;
      if (capture)    hold_vld_p1 <= 1'b1;
      else if (leave) hold_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)  bus_p1        <= es_to_ms_bus;
    if (capture) rdata_hold_p1 <= data_sram_rdata;
  end

  // ---- stage p1 -> WB / decode forward: combinational outputs ----
  assign mem_data     = hold_vld_p1 ? rdata_hold_p1 : data_sram_rdata;
  assign final_result = res_from_mem
                        ? load_align(mem_data, result[1:0], ld_lw, ld_lb,
                                     ld_lbu, ld_lh, ld_lhu)
                        : result;

`ifdef MS_ADDR_CHK_EN
  assign ms_adel = vld_p1 && ((ld_lw && (result[1:0] != 2'b00)) ||
                              ((ld_lh || ld_lhu) && result[0]));
`else
  assign ms_adel = 1'b0;
`endif

  assign gr_we_out    = gr_we && vld_p1 && !ms_adel;
  assign fw_valid     = vld_p1 && dest_valid && !ms_adel;
  assign ms_to_ws_bus = {gr_we_out, dest, final_result, pc};
  assign ms_to_ds_fw  = {fw_valid, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

`ifdef MS_ADDR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [76:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [37:0] ms_to_ds_fw;
  logic        ms_adel;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ms_to_ds_fw(ms_to_ds_fw), .ms_adel(ms_adel)
  );

  always #5 clk = ~clk;

  // kind: 0 alu, 1 lw, 2 lb, 3 lbu, 4 lh, 5 lhu
  typedef struct {
    int          kind;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [31:0] exp_final;
    logic        exp_adel;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [76:0] mk_bus(input int kind, input logic dv, input logic we,
                                         input logic [4:0] dest, input logic [31:0] res,
                                         input logic [31:0] pc);
    logic [4:0] f;
    f = '0;
    if (kind >= 1 && kind <= 5) f[kind-1] = 1'b1;
    return {f[4], f[3], f[2], f[1], f[0], dv, (kind != 0), we, dest, res, pc};
  endfunction

  // Reference load extension written with plain integer arithmetic.
  function automatic logic [31:0] ref_load(input int kind, input logic [31:0] w,
                                           input logic [1:0] a);
    longint v;
    case (kind)
      1: return w;
      2, 3: begin
        v = (longint'(w) >> (8 * int'(a))) % 256;
        if (kind == 2 && v >= 128) v -= 256;
        return 32'(v);
      end
      4, 5: begin
        v = (longint'(w) >> (a[1] ? 16 : 0)) % 65536;
        if (kind == 4 && v >= 32768) v -= 65536;
        return 32'(v);
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_adel(input int kind, input logic [1:0] a);
    return CHK && ((kind == 1 && a != 2'b00) || ((kind == 4 || kind == 5) && a[0]));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  // model state for the random phase
  bit          m_occ;
  int          m_kind;
  logic        m_dv, m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_res, m_pc, m_first;
  int          m_age;

  initial begin
    logic [31:0] exp_fin;
    logic        exp_ad;
    int          kind;
    logic [4:0]  bd;
    logic [31:0] br;
    logic [31:0] res_q[$];
    logic [4:0]  dest_q[$];

    vecs[0] = '{1, 32'h0000_1000, 32'h8765_4321, 32'h8765_4321, 1'b0};
    vecs[1] = '{2, 32'h0000_1003, 32'h80AA_BBCC, 32'hFFFF_FF80, 1'b0};
    vecs[2] = '{3, 32'h0000_1003, 32'h80AA_BBCC, 32'h0000_0080, 1'b0};
    vecs[3] = '{4, 32'h0000_1002, 32'h80AA_BBCC, 32'hFFFF_80AA, 1'b0};
    vecs[4] = '{5, 32'h0000_1000, 32'h80AA_BBCC, 32'h0000_BBCC, 1'b0};
    vecs[5] = '{2, 32'h0000_1001, 32'h80AA_BBCC, 32'hFFFF_FFBB, 1'b0};
    vecs[6] = '{5, 32'h0000_1002, 32'h80AA_BBCC, 32'h0000_80AA, 1'b0};
    vecs[7] = '{0, 32'hDEAD_BEEF, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0};
    vecs[8] = '{4, 32'h0000_2001, 32'h1234_5678, 32'h0000_5678, CHK};
    vecs[9] = '{2, 32'h0000_2000, 32'h0000_007F, 32'h0000_007F, 1'b0};

    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", ms_to_ws_valid, 0);
    chk("reset_allowin", ms_allowin, 1);
    chk("reset_fw_valid", ms_to_ds_fw[37], 0);
    chk("reset_adel", ms_adel, 0);
    tick();
    resetn = 1'b1;
    tick();

    // table-driven single-entry loads/alu ops
    for (int i = 0; i < 10; i++) begin
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(vecs[i].kind, 1'b1, 1'b1, 5'(i + 1), vecs[i].result, 32'hBFC0_0000 + 32'(i * 4));
      ws_allowin = 1'b1;
      tick();
      es_to_ms_valid = 1'b0;
      data_sram_rdata = vecs[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), ms_to_ws_valid, 1);
      chk($sformatf("vec%0d_final", i), ms_to_ws_bus[63:32], vecs[i].exp_final);
      chk($sformatf("vec%0d_gr_we", i), ms_to_ws_bus[69], !vecs[i].exp_adel);
      chk($sformatf("vec%0d_adel", i), ms_adel, vecs[i].exp_adel);
      chk($sformatf("vec%0d_fw", i), ms_to_ds_fw, {!vecs[i].exp_adel, 5'(i + 1), vecs[i].exp_final});
      tick();
    end
    chk("drain_valid", ms_to_ws_valid, 0);

    // lw stalled by WB for 3 cycles while SRAM output keeps changing;
    // EX keeps offering an alu op that must wait.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1, 1'b1, 1'b1, 5'd7, 32'h0000_3000, 32'h100);
    tick();
    es_to_ms_bus = mk_bus(0, 1'b1, 1'b1, 5'd9, 32'h5555_AAAA, 32'h104);
    ws_allowin = 1'b0;
    for (int c = 0; c < 3; c++) begin
      data_sram_rdata = 32'hCAFE_0000 + 32'(c);
      @(negedge clk);
      chk($sformatf("hold%0d_allowin", c), ms_allowin, 0);
      chk($sformatf("hold%0d_final", c), ms_to_ws_bus[63:32], 32'hCAFE_0000);
      tick();
    end
    ws_allowin = 1'b1;
    data_sram_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("hold_release_final", ms_to_ws_bus[63:32], 32'hCAFE_0000);
    chk("hold_release_pc", ms_to_ws_bus[31:0], 32'h100);
    tick();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("enter_leave_final", ms_to_ws_bus[63:32], 32'h5555_AAAA);
    chk("enter_leave_dest", ms_to_ws_bus[68:64], 9);
    tick();

    // reset asserted while a load's data is held
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1, 1'b1, 1'b1, 5'd3, 32'h0000_4000, 32'h200);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'hEEEE_0001;
    tick();
    data_sram_rdata = 32'hEEEE_0002;
    resetn = 1'b0;
    #1;
    chk("rst_mid_valid", ms_to_ws_valid, 0);
    chk("rst_mid_allowin", ms_allowin, 1);
    chk("rst_mid_fw", ms_to_ds_fw[37], 0);
    tick();
    resetn = 1'b1;
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", ms_to_ws_valid, 0);
    chk("post_rst_allowin", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h300);
    tick();
    es_to_ms_valid = 1'b0;
    data_sram_rdata = 32'h7777_1234;
    @(negedge clk);
    chk("hold_dropped_final", ms_to_ws_bus[63:32], 32'h7777_1234);
    tick();

    // back-to-back alu ops, dest 0 included
    ws_allowin = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bd = 5'(k * 3);
      br = $urandom;
      res_q.push_back(br);
      dest_q.push_back(bd);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(0, 1'b1, 1'b1, bd, br, 32'(k));
      tick();
      @(negedge clk);
      chk($sformatf("b2b%0d_fw", k), ms_to_ds_fw, {1'b1, dest_q.pop_front(), res_q.pop_front()});
    end
    es_to_ms_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bubble_fw_valid", ms_to_ds_fw[37], 0);

    // randomized phase against the occupancy model
    m_occ = 0; m_age = 0; m_kind = 0;
    m_dv = 0; m_we = 0; m_dest = 0; m_res = 0; m_pc = 0; m_first = 0;
    tick();
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 5));
      es_to_ms_valid = ($urandom_range(0, 3) != 0);
      es_to_ms_bus = mk_bus(kind, 1'($urandom), 1'($urandom), 5'($urandom),
                            $urandom, $urandom);
      ws_allowin = ($urandom_range(0, 9) < 7);
      data_sram_rdata = $urandom;
      @(negedge clk);
      if (m_occ && m_age == 0) m_first = data_sram_rdata;
      chk("rnd_valid", ms_to_ws_valid, m_occ);
      chk("rnd_allowin", ms_allowin, !m_occ || ws_allowin);
      if (m_occ) begin
        exp_ad  = ref_adel(m_kind, m_res[1:0]);
        exp_fin = (m_kind == 0) ? m_res : ref_load(m_kind, m_first, m_res[1:0]);
        chk("rnd_bus", ms_to_ws_bus, {m_we && !exp_ad, m_dest, exp_fin, m_pc});
        chk("rnd_fw", ms_to_ds_fw, {m_dv && !exp_ad, m_dest, exp_fin});
        chk("rnd_adel", ms_adel, exp_ad);
      end else begin
        chk("rnd_fw_bubble", ms_to_ds_fw[37], 0);
      end
      @(posedge clk);
      if (!m_occ || ws_allowin) begin
        m_occ = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_kind = es_to_ms_bus[76] ? 5 : es_to_ms_bus[75] ? 4 : es_to_ms_bus[74] ? 3 :
                   es_to_ms_bus[73] ? 2 : es_to_ms_bus[72] ? 1 : 0;
          m_dv   = es_to_ms_bus[71];
          m_we   = es_to_ms_bus[69];
          m_dest = es_to_ms_bus[68:64];
          m_res  = es_to_ms_bus[63:32];
          m_pc   = es_to_ms_bus[31:0];
          m_age  = 0;
        end
      end else begin
        m_age++;
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
